// File: rtl/iter_shifter_if.sv
// Request/result bundle between the control unit and the multi-cycle shifter.
// The master holds the pipeline while busy_o is high and takes out_o when done_o pulses.
interface iter_shifter_if #(
   parameter int WIDTH = 16
) ();
   // Handshake: start_i is sampled only while busy_o is low. busy_o rises on the
   // cycle after acceptance and falls with the single-cycle done_o pulse. out_o is
   // valid from that pulse until the next accepted start.
   logic             start_i;
   logic [WIDTH-1:0] in_i;
   logic [3:0]       shamt_i;
   logic [1:0]       oper_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] out_o;

   modport master (
      output start_i, in_i, shamt_i, oper_i,
      input  busy_o, done_o, out_o
   );

   modport slave (
      input  start_i, in_i, shamt_i, oper_i,
      output busy_o, done_o, out_o
   );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle rotate-right / shift unit: 2 bits per clock, 1-bit final step for odd amounts.
// Data is 16 bits wide; the 4-bit amount covers the full 0-15 range.
module iter_shifter #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   iter_shifter_if.slave bus,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   state_e           state_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic [3:0]       rem_q, rem_d;
   logic [1:0]       op_q;
   logic             busy_q, done_q;
   logic             two_step;

   // One step of the captured operation; the step size follows the remaining amount.
   always_comb begin
      two_step = (rem_q >= 4'd2);
      rem_d    = two_step ? (rem_q - 4'd2) : 4'd0;
      data_d   = data_q;
      case (op_q)
         OP_ROR: data_d = two_step ? {data_q[1:0], data_q[WIDTH-1:2]}
                                   : {data_q[0], data_q[WIDTH-1:1]};
         OP_SLL: data_d = two_step ? {data_q[WIDTH-3:0], 2'b00}
                                   : {data_q[WIDTH-2:0], 1'b0};
         OP_SRA: data_d = two_step ? {{2{data_q[WIDTH-1]}}, data_q[WIDTH-1:2]}
                                   : {data_q[WIDTH-1], data_q[WIDTH-1:1]};
         OP_SRL: data_d = two_step ? {2'b00, data_q[WIDTH-1:2]}
                                   : {1'b0, data_q[WIDTH-1:1]};
         default: data_d = data_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= 4'd0;
         op_q    <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start_i) begin
                  data_q <= bus.in_i;
                  rem_q  <= bus.shamt_i;
                  op_q   <= bus.oper_i;
                  busy_q <= 1'b1;
                  // A zero amount skips straight to the completion cycle.
                  if (bus.shamt_i != 4'd0) begin
                     state_q <= SHIFT;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               data_q <= data_d;
               rem_q  <= rem_d;
               if (rem_d == 4'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.out_o  = data_q;
   assign state_o    = state_q;

endmodule
